// File: rtl/wb_write_arbiter.sv
// Register-file write-port arbiter: pipeline write-back versus late multi-cycle results
// queued in a small FIFO, with starvation forcing, order hazards and a pending-register check.
module wb_write_arbiter #(
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_wbValid,
    input  logic [4:0]                     i_wbRd,
    input  logic [31:0]                    i_wbData,
    output logic                           o_wbStall,
    input  logic                           i_mcValid,
    output logic                           o_mcReady,
    input  logic [4:0]                     i_mcRd,
    input  logic [31:0]                    i_mcData,
    input  logic [4:0]                     i_chkRs1,
    input  logic [4:0]                     i_chkRs2,
    output logic [1:0]                     o_rsPending,
    output logic                           o_rfWe,
    output logic [4:0]                     o_rfRd,
    output logic [31:0]                    o_rfData,
    output logic [$clog2(DEPTH+1)-1:0]     o_pendCount
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = $clog2(STARVE_MAX + 1);

    typedef enum logic {
        ST_NORMAL,
        ST_FORCE
    } state_t;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_PIPE,
        GNT_HEAD
    } grant_t;

    state_t          state, state_next;
    grant_t          grant;
    logic [SW-1:0]   starve_cnt, starve_next;
    logic [PW-1:0]   rd_ptr, wr_ptr;
    logic [CW-1:0]   pend_count, count_next;

    logic [4:0]      fifo_rd   [DEPTH];
    logic [31:0]     fifo_data [DEPTH];
    logic [DEPTH-1:0] entry_valid;

    logic            p_req, h_req, z_hazard, push, pop, mc_ready;
    logic            wb_match, rs1_match, rs2_match;

    // ------------------------------------------------------------------
    // Request decode and FIFO entry occupancy
    // ------------------------------------------------------------------
    assign p_req    = i_wbValid && (i_wbRd != 5'd0);
    assign h_req    = (pend_count != '0);
    assign mc_ready = !i_rst && (pend_count < CW'(DEPTH));
    // rd 0 results complete the handshake but never occupy an entry.
    assign push     = i_mcValid && mc_ready && (i_mcRd != 5'd0);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned and infers a latch.
        entry_valid = '0;
        wb_match    = 1'b0;
        rs1_match   = 1'b0;
        rs2_match   = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            entry_valid[i] = CW'(PW'(PW'(i) - rd_ptr)) < pend_count;
            if (entry_valid[i]) begin
                if (fifo_rd[i] == i_wbRd)   wb_match  = 1'b1;
                if (fifo_rd[i] == i_chkRs1) rs1_match = 1'b1;
                if (fifo_rd[i] == i_chkRs2) rs2_match = 1'b1;
            end
        end
    end

    // The multi-cycle instruction is older, so an equal rd must reach the file first.
    assign z_hazard = p_req && (wb_match || (push && (i_mcRd == i_wbRd)));

    // ------------------------------------------------------------------
    // Arbitration FSM, combinational half
    // ------------------------------------------------------------------
    always_comb begin
        grant       = GNT_NONE;
        state_next  = state;
        starve_next = starve_cnt;

        unique case (state)
            ST_NORMAL: begin
                if (p_req && !z_hazard) grant = GNT_PIPE;
                else if (h_req)         grant = GNT_HEAD;
            end
            ST_FORCE: begin
                if (h_req) grant = GNT_HEAD;
            end
            default: grant = GNT_NONE;
        endcase

        if ((grant == GNT_HEAD) || !h_req)
            starve_next = '0;
        else if (starve_cnt != SW'(STARVE_MAX))
            starve_next = starve_cnt + 1'b1;

        unique case (state)
            ST_NORMAL: if (starve_next == SW'(STARVE_MAX)) state_next = ST_FORCE;
            ST_FORCE:  if (grant == GNT_HEAD)              state_next = ST_NORMAL;
            default:   state_next = ST_NORMAL;
        endcase
    end

    assign pop = (grant == GNT_HEAD);

    always_comb begin
        count_next = pend_count;
        unique case ({push, pop})
            2'b10:   count_next = pend_count + 1'b1;
            2'b01:   count_next = pend_count - 1'b1;
            default: count_next = pend_count;
        endcase
    end

    // ------------------------------------------------------------------
    // State, pointers and the registered write port
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= ST_NORMAL;
            starve_cnt <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            pend_count <= '0;
            o_rfWe     <= 1'b0;
            o_rfRd     <= 5'd0;
            o_rfData   <= 32'd0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            state      <= state_next;
            starve_cnt <= starve_next;
            pend_count <= count_next;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;

            unique case (grant)
                GNT_PIPE: begin
                    o_rfWe   <= 1'b1;
                    o_rfRd   <= i_wbRd;
                    o_rfData <= i_wbData;
                end
                GNT_HEAD: begin
                    o_rfWe   <= 1'b1;
                    o_rfRd   <= fifo_rd[rd_ptr];
                    o_rfData <= fifo_data[rd_ptr];
                end
                default: o_rfWe <= 1'b0;
            endcase
        end
    end

    // NOTE: the FIFO storage is not reset; occupancy and pointers alone decide which entries are meaningful.
    always_ff @(posedge i_clk) begin
        if (push) begin
            fifo_rd[wr_ptr]   <= i_mcRd;
            fifo_data[wr_ptr] <= i_mcData;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign o_mcReady   = mc_ready;
    assign o_wbStall   = p_req && (grant != GNT_PIPE);
    assign o_pendCount = pend_count;
    assign o_rsPending = {rs2_match && (i_chkRs2 != 5'd0),
                          rs1_match && (i_chkRs1 != 5'd0)};

    a_no_overflow : assert property (@(posedge i_clk) disable iff (i_rst)
        pend_count <= CW'(DEPTH));

endmodule

// File: doc/wb_write_arbiter.md
# wb_write_arbiter

Arbitrates the single register-file write port between the in-order pipeline's write-back result (the already-selected WB data) and results returned late by multi-cycle units such as mul/div. Late results are held in a small FIFO. The pipeline normally has priority. The FIFO takes the port when the pipeline has no write, when starvation forces it, or when program order requires it. Sits between the WB stage and the register file; also drives a pending-register hazard check back to decode.

## Interface
- `DEPTH`, 2: multi-cycle result FIFO entries; power of two, ≥2.
- `STARVE_MAX`, 4: consecutive cycles a FIFO head may lose arbitration before it is forced through; ≥1.

- `i_clk` in 1: the block's single clock.
- `i_rst` in 1: asynchronous, active-high reset.
- `i_wbValid` in 1: pipeline WB stage holds a register write.
- `i_wbRd` in 5: pipeline destination register.
- `i_wbData` in 32: pipeline write data.
- `o_wbStall` out 1: pipeline must hold WB this cycle (combinational).
- `i_mcValid` in 1: multi-cycle result offered.
- `o_mcReady` out 1: FIFO can accept; a transfer happens when valid && ready.
- `i_mcRd` in 5: multi-cycle destination register.
- `i_mcData` in 32: multi-cycle result data.
- `i_chkRs1` in 5: decode source register 1 to check.
- `i_chkRs2` in 5: decode source register 2 to check.
- `o_rsPending` out 2: bit0/bit1 set if rs1/rs2 (non-zero) matches any FIFO entry's rd.
- `o_rfWe` out 1: register-file write enable (registered).
- `o_rfRd` out 5: register-file write address (registered).
- `o_rfData` out 32: register-file write data (registered).
- `o_pendCount` out $clog2(DEPTH+1): current FIFO occupancy.

## Operation
- **Effective requests.**
  - Pipeline request (P) = `i_wbValid` && `i_wbRd` != 0.
  - A pipeline write with rd 0 completes immediately with no port use and no stall.
  - Multi-cycle transfers with rd 0 are accepted and discarded; they are not enqueued.
- **Head request.** H = `o_pendCount` > 0.
- **Order hazard (Z).**
  - Z is set when P is set and `i_wbRd` matches the rd of any valid FIFO entry.
  - Z is also set when P is set and `i_wbRd` matches an enqueuing transfer in the same cycle. The multi-cycle instruction is older, so it must be written first.
- **FSM states.**
  - NORMAL: the grant goes to P if P && !Z. Otherwise it goes to the head if H. Otherwise there is no grant.
  - FORCE: the grant goes to the head unconditionally.
  - NORMAL→FORCE when `starveCnt` == `STARVE_MAX` at a clock edge.
  - FORCE→NORMAL after one head pop.
- **Stall.** `o_wbStall` = P && (grant != pipeline).
- **Starvation counter (`starveCnt`).**
  - Clears on a head pop and whenever the FIFO is empty.
  - Otherwise increments (saturating at `STARVE_MAX`) each cycle H is set and the head is not granted.
- **FIFO.**
  - Circular, with read/write pointers wrapping modulo DEPTH.
  - `o_mcReady` = !`i_rst` && `o_pendCount` < DEPTH. It is registered-state based and has no combinational path from the pop.
  - Simultaneous push and pop leaves the count unchanged.
  - A push to a full FIFO cannot occur.
- **Write port.** Each edge loads `o_rfWe`/`o_rfRd`/`o_rfData` from the granted source. With no grant, `o_rfWe` = 0 and addr/data hold their previous values.
- **Hazard check.** `o_rsPending` is combinational over the valid FIFO entries only. It compares against registered state and excludes in-flight `o_rfWe` (the register file write-through covers that).
- **Reset (asynchronous).**
  - FIFO empty, pointers 0, `starveCnt` 0, FSM NORMAL.
  - `o_rfWe` 0, `o_rfRd` 0, `o_rfData` 0, `o_pendCount` 0.
  - `o_mcReady` 0 while `i_rst` is high; `o_wbStall` 0; `o_rsPending` 0.
  - Reset mid-drain discards all pending entries.

## Timing
- **Pipeline write:** granted in cycle N → `o_rfWe` high in cycle N+1 for exactly one cycle.
- **Multi-cycle result:** accepted at the end of cycle N → head in N+1 → earliest `o_rfWe` in N+2.
- **Starved head:** a head losing for `STARVE_MAX` consecutive cycles is granted in the next cycle. The pipeline is stalled that cycle if P.
- **Worst-case pipeline stall:** a Z-hazard stall lasts until all matching entries drain, at most DEPTH cycles for DEPTH=2 absent forced grants.
- **FIFO ordering:** entries write in FIFO order; a later entry never bypasses an earlier one.

## Test plan
- **Pipeline-only writes.**
  - Stimulus: `i_wbValid`=1, rd=5, data=0xDEADBEEF at N; rd=0 at N+1.
  - Required: `o_rfWe`=1/rd 5/0xDEADBEEF at N+1, `o_rfWe`=0 at N+2, `o_wbStall` never 1.
- **Idle drain.**
  - Stimulus: mc rd=7, data=0x12 accepted at N; pipeline idle.
  - Required: `o_pendCount`=1 at N+1, `o_rfWe` rd 7 data 0x12 at N+2, `o_pendCount`=0 at N+2.
- **Full FIFO and starvation** (DEPTH=2, STARVE_MAX=4).
  - Stimulus: two mc pushes (rd 3, rd 4), then continuous pipeline writes to rd 9.
  - Required: `o_mcReady`=0 while count is 2. rd 3 is forced after 4 lost cycles, with `o_wbStall`=1 that cycle. rd 4 is forced after another 4, in order 3 then 4.
- **Order hazard.**
  - Stimulus: FIFO holds rd 6 = 0xAA; pipeline writes rd 6 = 0xBB.
  - Required: `o_wbStall`=1 for one cycle. The register file sees 0xAA then 0xBB on consecutive cycles, and the final value is 0xBB.
- **Hazard report.**
  - Stimulus: FIFO holds rd 10; `i_chkRs1`=10, `i_chkRs2`=0.
  - Required: `o_rsPending`=2'b01, then 2'b00 in the cycle after the pop.
- **Reset mid-operation.**
  - Stimulus: assert `i_rst` asynchronously with 2 entries pending and the FSM in FORCE.
  - Required: `o_rfWe`=0, `o_pendCount`=0 and `o_mcReady`=0 immediately (no clock edge needed). After release, `o_mcReady`=1 and no stale writes occur.
